// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with per-frame input snapshot, PWM
// brightness, blink, leading-zero blanking and dead time between digit slots.
module seg_scan_display #(
  parameter int DIGITS     = 4,
  parameter int DIV_BITS   = 14,
  parameter int BLINK_BITS = 6,
  parameter int HEX        = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_suppress,
  input  logic [2:0]            brightness,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     choice_n,
  output logic                  frame_start
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_BITS-1:0]        pre_q, pre_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [BLINK_BITS-1:0]      blink_q, blink_d;
  logic                       blink_off_q, blink_off_d;
  logic [DIGITS-1:0][3:0]     snap_dig_q, snap_dig_d;
  logic [DIGITS-1:0]          snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]          snap_mask_q, snap_mask_d;
  logic [6:0]                 seg_n_q, seg_n_d;
  logic                       dp_n_q, dp_n_d;
  logic [DIGITS-1:0]          choice_n_q, choice_n_d;
  logic                       fs_q, fs_d;

  logic                       fs_now;
  logic [2:0]                 phase;
  logic [3:0]                 cur_code;
  logic [DIGITS-1:0]          blank;
  logic                       higher_zero;
  logic                       lit;

  function automatic logic [6:0] dec7(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      default: begin
        if (HEX != 0) begin
          case (c)
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
          endcase
        end else begin
          s = (c == 4'hF) ? 7'b0111111 : 7'b0000110;
        end
      end
    endcase
    return s;
  endfunction

  // Leading-zero blanking walks down from the most significant digit.
  always_comb begin
    blank       = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      blank[i]    = lz_suppress && higher_zero && (snap_dig_q[i] == 4'h0) && (i != 0);
      higher_zero = higher_zero && (snap_dig_q[i] == 4'h0);
    end
  end

  always_comb begin
    fs_now      = (pre_q == '0) && (idx_q == '0);
    pre_d       = pre_q + 1'b1;
    idx_d       = idx_q;
    if (pre_q == '1)
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    blink_d     = blink_q;
    blink_off_d = blink_off_q;
    snap_dig_d  = snap_dig_q;
    snap_dp_d   = snap_dp_q;
    snap_mask_d = snap_mask_q;
    // Blink state is frozen per frame alongside the digit snapshot.
    if (fs_now) begin
      blink_d     = blink_q + 1'b1;
      blink_off_d = blink_q[BLINK_BITS-1];
      snap_dig_d  = digits;
      snap_dp_d   = dp;
      snap_mask_d = blink_mask;
    end
  end

  always_comb begin
    phase      = pre_q[DIV_BITS-1 -: 3];
    cur_code   = snap_dig_q[idx_q];
    lit        = enable && (phase != 3'd0) && (phase <= brightness)
                 && !(blink_off_q && snap_mask_q[idx_q])
                 && !(blank[idx_q] && !snap_dp_q[idx_q]);
    choice_n_d = '1;
    seg_n_d    = 7'h7f;
    dp_n_d     = 1'b1;
    fs_d       = fs_now;
    if (lit) begin
      choice_n_d = ~(DIGITS'(1) << idx_q);
      seg_n_d    = blank[idx_q] ? 7'h7f : dec7(cur_code);
      dp_n_d     = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q       <= '0;
      idx_q       <= '0;
      blink_q     <= '0;
      blink_off_q <= 1'b0;
      snap_dig_q  <= '0;
      snap_dp_q   <= '0;
      snap_mask_q <= '0;
      seg_n_q     <= 7'h7f;
      dp_n_q      <= 1'b1;
      choice_n_q  <= '1;
      fs_q        <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      blink_q     <= blink_d;
      blink_off_q <= blink_off_d;
      snap_dig_q  <= snap_dig_d;
      snap_dp_q   <= snap_dp_d;
      snap_mask_q <= snap_mask_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
      choice_n_q  <= choice_n_d;
      fs_q        <= fs_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign choice_n    = choice_n_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench: a frame/slot arithmetic model predicts every output cycle
// for a decimal (HEX=0) and a hex (HEX=1) instance driven by the same stimulus.
module tb_seg_scan_display;
  localparam int D  = 4;
  localparam int DV = 4;
  localparam int BB = 2;
  localparam int SL = 1 << DV;
  localparam int FL = SL * D;

  logic        clock = 1'b1;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        lz = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0, bm = '0;
  logic [2:0]  br = '0;

  logic [6:0]  seg0, seg1;
  logic        dpn0, dpn1, fs0, fs1;
  logic [3:0]  ch0, ch1;

  always #5 clock = ~clock;

  seg_scan_display #(.DIGITS(D), .DIV_BITS(DV), .BLINK_BITS(BB), .HEX(0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .digits(digits), .dp(dp),
    .blink_mask(bm), .lz_suppress(lz), .brightness(br),
    .seg_n(seg0), .dp_n(dpn0), .choice_n(ch0), .frame_start(fs0));

  seg_scan_display #(.DIGITS(D), .DIV_BITS(DV), .BLINK_BITS(BB), .HEX(1)) dut_hex (
    .clock(clock), .reset(reset), .enable(enable), .digits(digits), .dp(dp),
    .blink_mask(bm), .lz_suppress(lz), .brightness(br),
    .seg_n(seg1), .dp_n(dpn1), .choice_n(ch1), .frame_start(fs1));

  typedef struct packed {
    logic [3:0] ch;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic       dpn;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   t = 0;
  logic [15:0] snap_d = '0;
  logic [3:0]  snap_dp = '0, snap_bm = '0;

  function automatic logic [6:0] ref_dec(input logic [3:0] c, input bit hex);
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return hex ? 7'b0001000 : 7'b0000110;
      4'hB: return hex ? 7'b0000011 : 7'b0000110;
      4'hC: return hex ? 7'b1000110 : 7'b0000110;
      4'hD: return hex ? 7'b0100001 : 7'b0000110;
      4'hE: return 7'b0000110;
      default: return hex ? 7'b0001110 : 7'b0111111;
    endcase
  endfunction

  function automatic exp_t dark(input bit fs);
    exp_t e;
    e.ch = 4'hF; e.seg0 = 7'h7f; e.seg1 = 7'h7f; e.dpn = 1'b1; e.fs = fs;
    return e;
  endfunction

  // Expected outputs after the edge that closes cycle tt (cycles counted from reset release).
  function automatic exp_t model(input int tt);
    exp_t e;
    int ph, ix, f;
    bit blank, boff, lit;
    logic [3:0] code;
    e    = dark(tt % FL == 0);
    ph   = (tt % SL) / (SL / 8);
    ix   = (tt / SL) % D;
    f    = tt / FL;
    boff = (f % (1 << BB)) >= (1 << (BB - 1));
    code = snap_d[ix*4 +: 4];
    blank = lz && (ix > 0);
    for (int j = ix; j < D; j++)
      if (snap_d[j*4 +: 4] != 4'h0) blank = 1'b0;
    lit = enable && (ph >= 1) && (ph <= int'(br)) && !(boff && snap_bm[ix])
          && !(blank && !snap_dp[ix]);
    if (lit) begin
      e.ch   = ~(4'(1) << ix);
      e.seg0 = blank ? 7'h7f : ref_dec(code, 1'b0);
      e.seg1 = blank ? 7'h7f : ref_dec(code, 1'b1);
      e.dpn  = ~snap_dp[ix];
    end
    return e;
  endfunction

  task automatic issue();
    q.push_back(model(t));
    if (t % FL == 0) begin
      snap_d = digits; snap_dp = dp; snap_bm = bm;
    end
    t++;
  endtask

  task automatic run_fixed(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      issue();
    end
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0)  digits = rand_digits();
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) br = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) lz = ~lz;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      issue();
    end
  endtask

  task automatic hold_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      q.push_back(dark(1'b0));
    end
  endtask

  // Monitor: every edge the DUTs present a new registered output word.
  always @(posedge clock) begin
    exp_t e;
    #1;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_underflow at %0t: no expected entry", $time);
    end else begin
      e = q.pop_front();
      if ({ch0, seg0, dpn0, fs0} !== {e.ch, e.seg0, e.dpn, e.fs}) begin
        n_bad++;
        $display("FAIL dec_out at %0t: got ch=%b seg=%b dp=%b fs=%b, want ch=%b seg=%b dp=%b fs=%b",
                 $time, ch0, seg0, dpn0, fs0, e.ch, e.seg0, e.dpn, e.fs);
      end
      n_cmp++;
      if ({ch1, seg1, dpn1, fs1} !== {e.ch, e.seg1, e.dpn, e.fs}) begin
        n_bad++;
        $display("FAIL hex_out at %0t: got ch=%b seg=%b dp=%b fs=%b, want ch=%b seg=%b dp=%b fs=%b",
                 $time, ch1, seg1, dpn1, fs1, e.ch, e.seg1, e.dpn, e.fs);
      end
    end
  end

  initial begin
    hold_reset(3);
    // Release on a negedge: the following cycle is cycle 0 of frame 0.
    @(negedge clock);
    reset = 1'b0; enable = 1'b1; br = 3'd7; digits = 16'h1234;
    issue();
    run_fixed(2 * FL - 1);
    digits = 16'h0070; lz = 1'b1;
    run_fixed(2 * FL);
    digits = 16'h0000;
    run_fixed(FL);
    dp = 4'b0100;
    run_fixed(2 * FL);
    digits = 16'hCAF1; dp = 4'b0000; lz = 1'b0; bm = 4'b0001; br = 3'd3;
    run_fixed(4 * FL);
    br = 3'd0;
    run_fixed(FL);
    run_random(24 * FL + 37);

    // Asynchronous reset mid-slot: outputs must go dark without an edge.
    @(negedge clock);
    enable = 1'b1; br = 3'd7; bm = '0; lz = 1'b0; digits = 16'h8888;
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({ch0, seg0, dpn0, ch1} !== {4'hF, 7'h7f, 1'b1, 4'hF}) begin
      n_bad++;
      $display("FAIL async_reset: got ch=%b seg=%b dp=%b ch_hex=%b, want all dark",
               ch0, seg0, dpn0, ch1);
    end
    q.push_back(dark(1'b0));
    hold_reset(2);
    @(negedge clock);
    reset = 1'b0; t = 0; snap_d = '0; snap_dp = '0; snap_bm = '0;
    issue();
    run_random(8 * FL);

    @(posedge clock);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
